// File: rtl/alu_issue_stage_pkg.sv
// Shared types and encodings for the ALU issue stage.
package alu_issue_stage_pkg;

   localparam int ISSUE_DATA_WIDTH = 32;
   localparam int ISSUE_REG_WIDTH  = 5;

   localparam logic [6:0] OPCODE_OP        = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
   localparam logic [6:0] FUNCT7_SUB       = 7'b0100000;
   localparam logic [6:0] SHIFT_FUNCT7_SRL = 7'b0000000;
   localparam logic [6:0] SHIFT_FUNCT7_SRA = 7'b0100000;

   // ALU code path, same encoding as RV32I funct3
   typedef enum logic [2:0] {
      ALU_ADD_SUB = 3'd0,
      ALU_SLL     = 3'd1,
      ALU_SLT     = 3'd2,
      ALU_SLTU    = 3'd3,
      ALU_XOR     = 3'd4,
      ALU_SRL_SRA = 3'd5,
      ALU_OR      = 3'd6,
      ALU_AND     = 3'd7
   } alu_code_e;

   // One decoded entry as held in the main/skid registers
   typedef struct packed {
      logic                        valid;
      logic [ISSUE_DATA_WIDTH-1:0] a;
      logic [ISSUE_DATA_WIDTH-1:0] b;
      alu_code_e                   code;
      logic [6:0]                  funct7;
      logic [ISSUE_REG_WIDTH-1:0]  rd;
      logic                        illegal;
   } IssueEntry;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (register read) and downstream (ALU) handshake bundle.
interface alu_issue_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int REG_NUM_WIDTH = 5
);
   logic                     inValid;
   logic                     inReady;
   logic [31:0]              insn;
   logic [DATA_WIDTH-1:0]    rs1Data;
   logic [DATA_WIDTH-1:0]    rs2Data;
   logic                     outValid;
   logic                     outReady;
   logic [DATA_WIDTH-1:0]    aluInA;
   logic [DATA_WIDTH-1:0]    aluInB;
   logic [2:0]               aluCode;
   logic [6:0]               funct7;
   logic [REG_NUM_WIDTH-1:0] rdAddr;
   logic                     illegal;

   // Driver of instructions and consumer of issued entries
   modport master (
      output inValid, insn, rs1Data, rs2Data, outReady,
      input  inReady, outValid, aluInA, aluInB, aluCode, funct7, rdAddr, illegal
   );

   // The issue stage itself
   modport slave (
      input  inValid, insn, rs1Data, rs2Data, outReady,
      output inReady, outValid, aluInA, aluInB, aluCode, funct7, rdAddr, illegal
   );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational OP / OP-IMM decode into an ALU-ready entry.
module alu_issue_decode
   import alu_issue_stage_pkg::*;
(
   input  logic [31:0]                 insn,
   input  logic [ISSUE_DATA_WIDTH-1:0] rs1Data,
   input  logic [ISSUE_DATA_WIDTH-1:0] rs2Data,
   output IssueEntry                   entry
);
   logic [6:0] opcode;
   logic [6:0] f7;
   logic [2:0] f3;
   logic       unused_rs1_field;

   assign opcode           = insn[6:0];
   assign f3               = insn[14:12];
   assign f7               = insn[31:25];
   assign unused_rs1_field = ^insn[19:15];

   // Shape operand B / funct7 for the ALU; anything unrecognised is marked illegal
   always_comb begin
      entry         = '0;
      entry.valid   = 1'b1;
      entry.a       = rs1Data;
      entry.rd      = insn[11:7];
      entry.code    = alu_code_e'(f3);
      entry.funct7  = 7'd0;
      entry.b       = '0;
      entry.illegal = 1'b0;
      case (opcode)
         OPCODE_OP: begin
            if (f7 == 7'd0) begin
               entry.b = rs2Data;
            end else if (f7 == FUNCT7_SUB && f3 == 3'b000) begin
               // ALU ADD_SUB only adds, so SUB arrives pre-negated
               entry.b = ~rs2Data + 32'd1;
            end else if (f7 == SHIFT_FUNCT7_SRA && f3 == 3'b101) begin
               entry.b      = rs2Data;
               entry.funct7 = SHIFT_FUNCT7_SRA;
            end else begin
               entry.illegal = 1'b1;
            end
         end
         OPCODE_OP_IMM: begin
            if (f3 == 3'b001) begin
               entry.b       = {27'd0, insn[24:20]};
               entry.illegal = (f7 != 7'd0);
            end else if (f3 == 3'b101) begin
               entry.b       = {27'd0, insn[24:20]};
               entry.funct7  = f7;
               entry.illegal = (f7 != SHIFT_FUNCT7_SRL) && (f7 != SHIFT_FUNCT7_SRA);
            end else begin
               entry.b = {{20{insn[31]}}, insn[31:20]};
            end
         end
         default: entry.illegal = 1'b1;
      endcase
      if (entry.illegal) begin
         entry.code   = ALU_ADD_SUB;
         entry.b      = '0;
         entry.funct7 = 7'd0;
      end
   end
endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: decode, then main + skid registers toward the ALU.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int DATA_WIDTH    = ISSUE_DATA_WIDTH,
   parameter int REG_NUM_WIDTH = ISSUE_REG_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   alu_issue_stage_if.slave  io
);
   IssueEntry dec;
   IssueEntry main_q;
   IssueEntry skid_q;
   logic      accept;
   logic      main_free;

   alu_issue_decode u_decode (
      .insn    (io.insn),
      .rs1Data (io.rs1Data),
      .rs2Data (io.rs2Data),
      .entry   (dec)
   );

   // inReady depends only on a flop; flush blocks consumption of the input
   assign io.inReady = ~skid_q.valid;
   assign accept     = io.inValid & ~skid_q.valid & ~flush;
   assign main_free  = ~main_q.valid | io.outReady;

   // Main/skid update; skid always drains into main before new input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_q.valid <= 1'b0;
         skid_q.valid <= 1'b0;
      end else if (main_free) begin
         if (skid_q.valid) begin
            main_q       <= skid_q;
            skid_q.valid <= 1'b0;
         end else if (accept) begin
            main_q <= dec;
         end else begin
            main_q.valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= dec;
      end
   end

   assign io.outValid = main_q.valid;
   assign io.aluInA   = main_q.a[DATA_WIDTH-1:0];
   assign io.aluInB   = main_q.b[DATA_WIDTH-1:0];
   assign io.aluCode  = main_q.code;
   assign io.funct7   = main_q.funct7;
   assign io.rdAddr   = main_q.rd[REG_NUM_WIDTH-1:0];
   assign io.illegal  = main_q.illegal;
endmodule
